// File: rtl/laser_point_rx_cover.sv
// laser_point_rx_cover: captures an NPTS-point pattern, then counts the points
// covered by either of two query circles using a one-point-per-cycle pipeline.
module laser_point_rx_cover #(
   parameter int NPTS      = 40,
   parameter int COORD_W   = 4,
   parameter int RADIUS_SQ = 16,
   parameter int CNT_W     = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [COORD_W-1:0] X,
   input  logic [COORD_W-1:0] Y,
   input  logic               rearm,
   output logic               loaded,
   input  logic               q_valid,
   output logic               q_ready,
   input  logic [COORD_W-1:0] q_c1x,
   input  logic [COORD_W-1:0] q_c1y,
   input  logic [COORD_W-1:0] q_c2x,
   input  logic [COORD_W-1:0] q_c2y,
   output logic               q_done,
   output logic [CNT_W-1:0]   q_cnt
);
   localparam int D_W = 2*COORD_W+1;
   localparam logic [D_W-1:0] LP_R = D_W'(RADIUS_SQ);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NPTS-1);

   typedef enum logic [1:0] {S_LOAD, S_IDLE, S_CALC, S_FLUSH} state_t;

   state_t               r_state, w_next;
   logic [CNT_W-1:0]     r_idx, r_acc, r_cnt;
   logic [COORD_W-1:0]   r_px [NPTS];
   logic [COORD_W-1:0]   r_py [NPTS];
   logic [COORD_W-1:0]   r_c1x, r_c1y, r_c2x, r_c2y;
   logic                 r_hit, r_hit_v, r_done;
   logic                 w_last, w_accept, w_hit;
   logic [COORD_W-1:0]   w_px, w_py;

   // Absolute differences are widened before squaring so 15^2+15^2 cannot alias.
   function automatic logic [D_W-1:0] dist_sq(input logic [COORD_W-1:0] ax, ay, bx, by);
      logic [D_W-1:0] dx, dy;
      dx = D_W'(ax > bx ? ax - bx : bx - ax);
      dy = D_W'(ay > by ? ay - by : by - ay);
      return dx*dx + dy*dy;
   endfunction

   assign w_last   = r_idx == LP_LAST;
   assign w_accept = r_state == S_IDLE && q_valid && !rearm;
   assign w_px     = r_px[r_idx];
   assign w_py     = r_py[r_idx];
   assign w_hit    = dist_sq(r_c1x, r_c1y, w_px, w_py) <= LP_R ||
                     dist_sq(r_c2x, r_c2y, w_px, w_py) <= LP_R;

   assign loaded  = r_state != S_LOAD;
   assign q_ready = r_state == S_IDLE;
   assign q_done  = r_done;
   assign q_cnt   = r_cnt;

   always_ff @(posedge CLK or posedge RST)
      if (RST) r_state <= S_LOAD;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (rearm)                            w_next = S_LOAD;
      else if (r_state == S_LOAD && w_last) w_next = S_IDLE;
      else if (w_accept)                    w_next = S_CALC;
      else if (r_state == S_CALC && w_last) w_next = S_FLUSH;
      else if (r_state == S_FLUSH)          w_next = S_IDLE;
   end

   // Point file needs no reset; it is always fully rewritten before use.
   always_ff @(posedge CLK)
      if (r_state == S_LOAD && !rearm) begin
         r_px[r_idx] <= X;
         r_py[r_idx] <= Y;
      end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_idx   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_hit   <= 1'b0;
         r_hit_v <= 1'b0;
         r_done  <= 1'b0;
         r_c1x   <= '0;
         r_c1y   <= '0;
         r_c2x   <= '0;
         r_c2y   <= '0;
      end else if (rearm) begin
         r_idx   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_hit_v <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= r_state == S_FLUSH;
         if (r_state == S_LOAD) r_idx <= w_last ? '0 : r_idx + 1'b1;
         if (w_accept) begin
            r_c1x   <= q_c1x;
            r_c1y   <= q_c1y;
            r_c2x   <= q_c2x;
            r_c2y   <= q_c2y;
            r_acc   <= '0;
            r_idx   <= '0;
            r_hit_v <= 1'b0;
         end
         if (r_state == S_CALC) begin
            r_hit   <= w_hit;
            r_hit_v <= 1'b1;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            r_acc   <= r_acc + {{(CNT_W-1){1'b0}}, r_hit_v & r_hit};
         end
         if (r_state == S_FLUSH) begin
            r_cnt   <= r_acc + {{(CNT_W-1){1'b0}}, r_hit_v & r_hit};
            r_hit_v <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_laser_point_rx_cover.sv
// tb_laser_point_rx_cover: directed checks of loading, cover counting,
// query protocol and abort behaviour of laser_point_rx_cover.
module tb_laser_point_rx_cover;
   logic       CLK = 1'b0, RST = 1'b1, rearm = 1'b0, q_valid = 1'b0;
   logic [3:0] X = '0, Y = '0, q_c1x = '0, q_c1y = '0, q_c2x = '0, q_c2y = '0;
   logic       loaded, q_ready, q_done;
   logic [5:0] q_cnt;
   int         n_tests = 0, n_fail = 0;

   laser_point_rx_cover dut (
      .CLK(CLK), .RST(RST), .X(X), .Y(Y), .rearm(rearm), .loaded(loaded),
      .q_valid(q_valid), .q_ready(q_ready),
      .q_c1x(q_c1x), .q_c1y(q_c1y), .q_c2x(q_c2x), .q_c2y(q_c2y),
      .q_done(q_done), .q_cnt(q_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called on a negedge whose next posedge samples point 0.
   task automatic load_pts(input int na, input logic [3:0] ax, ay, bx, by);
      int ds = 0;
      for (int i = 0; i < 40; i++) begin
         X = i < na ? ax : bx;
         Y = i < na ? ay : by;
         if (i == 20) chk("ready_in_load", q_ready, 1'b0);
         if (i == 39) chk("loaded_early", loaded, 1'b0);
         @(posedge CLK);
         @(negedge CLK);
         ds = ds + int'(q_done);
      end
      chk("no_done_load", ds, 0);
      chk("loaded", loaded, 1'b1);
      chk("ready_after_load", q_ready, 1'b1);
   endtask

   task automatic rearm_pulse();
      rearm = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      rearm = 1'b0;
      chk("rearm_loaded", loaded, 1'b0);
      chk("rearm_ready", q_ready, 1'b0);
      chk("rearm_cnt", q_cnt, 0);
   endtask

   task automatic start_q(input logic [3:0] a, b, c, d);
      int w = 0;
      while (!q_ready && w < 100) begin
         @(negedge CLK);
         w++;
      end
      chk("ready_wait", q_ready, 1'b1);
      q_valid = 1'b1;
      q_c1x = a; q_c1y = b; q_c2x = c; q_c2y = d;
      @(posedge CLK);
      #1;
      q_valid = 1'b0;
      q_c1x = 4'd8; q_c1y = 4'd8; q_c2x = 4'd8; q_c2y = 4'd8;
   endtask

   task automatic wait_done(input string tag, input int exp);
      int n = 0;
      do begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end while (!q_done && n < 60);
      chk({tag, "_lat"}, n, 41);
      chk({tag, "_cnt"}, q_cnt, exp);
   endtask

   initial begin
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_loaded", loaded, 1'b0);
      chk("rst_ready", q_ready, 1'b0);
      chk("rst_done", q_done, 1'b0);
      chk("rst_cnt", q_cnt, 0);
      RST = 1'b0;
      load_pts(40, 0, 0, 0, 0);
      start_q(0, 0, 15, 15);
      wait_done("full", 40);
      @(negedge CLK);
      chk("done_pulse", q_done, 1'b0);
      chk("cnt_hold", q_cnt, 40);

      rearm_pulse();
      load_pts(20, 4, 0, 4, 1);
      start_q(0, 0, 15, 15);
      wait_done("radius", 20);

      rearm_pulse();
      load_pts(40, 7, 7, 7, 7);
      start_q(5, 7, 9, 7);
      wait_done("overlap", 40);

      q_valid = 1'b1;
      rearm_pulse();
      load_pts(10, 15, 15, 0, 0);
      q_valid = 1'b0;
      start_q(0, 0, 0, 0);
      wait_done("ext_lo", 30);
      chk("b2b_ready", q_ready, 1'b1);
      start_q(15, 15, 15, 15);
      wait_done("ext_hi", 10);

      start_q(0, 0, 0, 0);
      repeat (10) @(negedge CLK);
      rearm_pulse();
      load_pts(40, 3, 3, 3, 3);
      start_q(3, 3, 15, 0);
      wait_done("abort", 40);

      start_q(3, 3, 3, 3);
      repeat (10) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("arst_loaded", loaded, 1'b0);
      chk("arst_ready", q_ready, 1'b0);
      chk("arst_done", q_done, 1'b0);
      chk("arst_cnt", q_cnt, 0);
      @(negedge CLK);
      RST = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/laser_point_rx_cover.md
Name: laser_point_rx_cover

Overview:
- Point-receive front end and coverage evaluator for the LASER core.
- Captures the 40-point stream that the host drives on X/Y after reset, one point per cycle, into an internal point file.
- Then serves coverage queries. Each query carries two candidate circle centres and returns how many stored points lie within distance² ≤ RADIUS_SQ of either centre; a point inside both circles counts once.
- The LASER search FSM issues one query per candidate pair and uses the returned count to select its output C1/C2.

Parameters:
- NPTS, 40: points per pattern.
- COORD_W, 4: coordinate width (0..15 grid).
- RADIUS_SQ, 16: inclusive squared-radius cover threshold.
- CNT_W, 6: count width, equal to clog2(NPTS+1).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- X  in  COORD_W  incoming point x.
- Y  in  COORD_W  incoming point y.
- rearm  in  1  single-cycle pulse; restarts point loading for the next pattern.
- loaded  out  1  high while a complete NPTS-point set is held.
- q_valid  in  1  query request.
- q_ready  out  1  query can be accepted.
- q_c1x, q_c1y, q_c2x, q_c2y  in  COORD_W each  candidate centres.
- q_done  out  1  single-cycle result strobe.
- q_cnt  out  CNT_W  covered-point count.

Behaviour:
- Reset (async, any state): state=LOAD, load index=0, loaded=0, q_ready=0, q_done=0, q_cnt=0. Point file contents are don't-care.
- Loading:
  - Point i (i=0..NPTS-1) is sampled on the (i+1)-th rising edge after RST deasserts, or after the edge that sampled rearm=1.
  - No valid qualifier; X/Y are unconditionally captured on those NPTS edges.
  - On the edge storing point NPTS-1: state→IDLE, loaded=1, q_ready=1.
  - X/Y are ignored in every state other than LOAD.
- States and transitions:
  - LOAD → IDLE: after NPTS samples.
  - IDLE → CALC: on q_valid && q_ready.
  - CALC → FLUSH: after the last point is issued.
  - FLUSH → IDLE: after the final accumulate; q_done fires here.
  - Any state → LOAD: on rearm=1. Any in-flight query is aborted, no q_done is produced, and loaded, q_ready and q_cnt clear to 0.
- Query accept:
  - Accept happens at edge T where q_valid && q_ready. The four centres are latched at T and q_ready drops.
  - q_valid while q_ready=0 is ignored and not queued.
  - Centre inputs may change after T without effect.
- Arithmetic, per point, using the latched centres:
  - dx = |cx − px| as unsigned COORD_W bits, no wrap.
  - d² = dx² + dy², 9 bits (max 450).
  - hit = (d1² ≤ RADIUS_SQ) OR (d2² ≤ RADIUS_SQ).
- Pipeline timing:
  - Point k's hit is registered at edge T+1+k.
  - The accumulator adds the hit at edge T+2+k and is cleared at T.
  - Result strobe: q_cnt updates, and q_done=1 for exactly one cycle, after edge T+NPTS+1.
  - Total latency from accept to q_done is NPTS+1 edges (41 by default).
  - q_ready returns high in the same cycle as q_done, so back-to-back accept on that edge is legal.
- q_cnt holds its value until the next q_done, rearm or reset. Range 0..NPTS, no saturation needed.
- Simultaneous q_valid and rearm: rearm wins; the query is not accepted.

Test Plan:
- Basic load and full cover: RST for 2 cycles, stream 40×(0,0), query C1=(0,0), C2=(15,15).
  - loaded=1 after 40 samples.
  - q_done exactly 41 edges after accept, q_cnt=40.
- Boundary radius: points (4,0)×20 and (4,1)×20, query C1=(0,0), C2=(15,15) → q_cnt=20 (distance² 16 counted, 17 not).
- Overlap no double count: 40×(7,7), query C1=(5,7), C2=(9,7) → q_cnt=40, not 80.
- Extremes and no-wrap: points (15,15)×10 and (0,0)×30.
  - Query C1=C2=(0,0) → q_cnt=30.
  - Query C1=(15,15), C2=(15,15) → q_cnt=10 (abs-diff 15, d²=450, must not alias).
- Protocol:
  - q_valid held during LOAD → no accept, q_ready=0.
  - Back-to-back queries on the q_done cycle → two strobes 41 edges apart, each count correct.
- Abort paths:
  - RST asserted mid-CALC → all outputs 0 immediately, asynchronously.
  - rearm mid-CALC → no q_done; a new 40-point load of all (3,3), then query C1=(3,3) → q_cnt=40.
